// File: rtl/ahbl_i2s_tx_if.sv
// AHB-Lite slave bus bundle for the I2S transmitter.
// master: drives address/control/write data and the DMAC push qualifier.
// slave : returns read data and HREADYOUT.
interface ahbl_i2s_tx_if;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        DMAC_interaction;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HSEL, HREADY, DMAC_interaction,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HSEL, HREADY, DMAC_interaction,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/ahbl_i2s_tx.sv
// AHB-Lite I2S master transmitter. Channel words are pushed into a FIFO over
// the bus (or by the DMAC) and shifted MSB-first on SD, left then right.
// Ports:
//   HCLK, HRESET     : clock, synchronous active-high reset
//   bus (slave)      : AHB-Lite register interface plus DMAC push qualifier
//   SCK, WS, SD      : I2S bit clock, word select (1 = right), serial data
//   IRQ              : one-cycle pulse when the FIFO level drains to THRESH
module ahbl_i2s_tx #(
  parameter int unsigned FIFO_AW    = 4,
  parameter logic [7:0]  DEF_DIV    = 8'd3,
  parameter int unsigned DEF_THRESH = 4
) (
  input  logic         HCLK,
  input  logic         HRESET,
  ahbl_i2s_tx_if.slave bus,
  output logic         SCK,
  output logic         WS,
  output logic         SD,
  output logic         IRQ
);
  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam int unsigned LvlW  = FIFO_AW + 1;
  localparam logic [LvlW-1:0]    LvlOne  = LvlW'(1);
  localparam logic [LvlW-1:0]    LvlFull = LvlW'(Depth);
  localparam logic [FIFO_AW-1:0] PtrOne  = FIFO_AW'(1);

  typedef enum logic {StIdle, StRun} state_e;

  logic [7:0]         addr_q;
  logic               trans_q, sel_q, write_q;
  logic               en_q, mono_q;
  logic [7:0]         clkdiv_q;
  logic [LvlW-1:0]    thresh_q;
  logic               underrun_q, overflow_q, irq_q;
  logic [31:0]        mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [LvlW-1:0]    level_q, level_d;

  state_e      state_q, state_d;
  logic [7:0]  half_q, half_d, div_q, div_d;
  logic        sck_q, sck_d, ws_q, ws_d;
  logic [5:0]  slot_q, slot_d;
  logic [31:0] shift_q, shift_d, left_q, left_d;

  logic        we, rd, reg_we, push, flush, status_rd;
  logic        fifo_empty, fifo_full, push_ok, pop_ok, pop_req, load_left;
  logic [31:0] status, rdata;
  logic        unused_bus;

  assign unused_bus = ^{bus.HADDR[31:8], bus.HTRANS[0], bus.HSIZE};

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q  <= '0;
      trans_q <= 1'b0;
      sel_q   <= 1'b0;
      write_q <= 1'b0;
    end else if (bus.HREADY) begin
      addr_q  <= bus.HADDR[7:0];
      trans_q <= bus.HTRANS[1];
      sel_q   <= bus.HSEL;
      write_q <= bus.HWRITE;
    end
  end

  // DMAC pushes take priority over any register decode of the same write.
  assign we        = trans_q & sel_q & write_q;
  assign rd        = trans_q & sel_q & ~write_q;
  assign reg_we    = we & ~bus.DMAC_interaction;
  assign push      = we & (bus.DMAC_interaction | (addr_q == 8'h08));
  assign flush     = reg_we & (addr_q == 8'h00) & bus.HWDATA[2];
  assign status_rd = rd & (addr_q == 8'h04);

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LvlFull);
  assign push_ok    = push & ~fifo_full & ~flush;
  assign pop_ok     = pop_req & ~fifo_empty;

  always_comb begin
    level_d = level_q;
    if (flush)                level_d = '0;
    else if (push_ok && !pop_ok) level_d = level_q + LvlOne;
    else if (!push_ok && pop_ok) level_d = level_q - LvlOne;
  end

  // Slot engine: each slot is 2*(div+1) cycles, SCK low in the first half.
  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    div_d     = div_q;
    sck_d     = sck_q;
    ws_d      = ws_q;
    slot_d    = slot_q;
    shift_d   = shift_q;
    left_d    = left_q;
    pop_req   = 1'b0;
    load_left = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_q && !fifo_empty) begin
          state_d   = StRun;
          half_d    = '0;
          div_d     = clkdiv_q;
          sck_d     = 1'b0;
          ws_d      = 1'b0;
          slot_d    = '0;
          pop_req   = 1'b1;
          load_left = 1'b1;
        end
      end
      StRun: begin
        if (half_q != div_q) begin
          half_d = half_q + 8'd1;
        end else if (!sck_q) begin
          half_d = '0;
          sck_d  = 1'b1;
        end else begin
          half_d = '0;
          sck_d  = 1'b0;
          div_d  = clkdiv_q;
          slot_d = slot_q + 6'd1;
          // WS switches one slot ahead of the channel data.
          ws_d   = (slot_d >= 6'd31) && (slot_d <= 6'd62);
          if (slot_q == 6'd63) begin
            if (!en_q) begin
              state_d = StIdle;
              ws_d    = 1'b0;
              shift_d = '0;
            end else begin
              pop_req   = 1'b1;
              load_left = 1'b1;
            end
          end else if (slot_q == 6'd31) begin
            if (mono_q) shift_d = left_q;
            else        pop_req = 1'b1;
          end else begin
            shift_d = {shift_q[30:0], 1'b0};
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop_req) begin
      shift_d = fifo_empty ? '0 : mem_q[rptr_q];
      if (load_left) left_d = shift_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push_ok) mem_q[wptr_q] <= bus.HWDATA;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      en_q       <= 1'b0;
      mono_q     <= 1'b0;
      clkdiv_q   <= DEF_DIV;
      thresh_q   <= LvlW'(DEF_THRESH);
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      state_q    <= StIdle;
      half_q     <= '0;
      div_q      <= '0;
      sck_q      <= 1'b0;
      ws_q       <= 1'b0;
      slot_q     <= '0;
      shift_q    <= '0;
      left_q     <= '0;
    end else begin
      if (reg_we) begin
        case (addr_q)
          8'h00: begin
            en_q   <= bus.HWDATA[0];
            mono_q <= bus.HWDATA[1];
          end
          8'h0C:   clkdiv_q <= bus.HWDATA[7:0];
          8'h10:   thresh_q <= bus.HWDATA[LvlW-1:0];
          default: ;
        endcase
      end
      // Set events win over the read-clear.
      underrun_q <= (pop_req & fifo_empty) | (underrun_q & ~status_rd);
      overflow_q <= (push & fifo_full & ~flush) | (overflow_q & ~status_rd);
      irq_q      <= en_q & ~flush & pop_ok & ~push_ok & ((level_q - LvlOne) == thresh_q);
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push_ok) wptr_q <= wptr_q + PtrOne;
        if (pop_ok)  rptr_q <= rptr_q + PtrOne;
      end
      level_q <= level_d;
      state_q <= state_d;
      half_q  <= half_d;
      div_q   <= div_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      slot_q  <= slot_d;
      shift_q <= shift_d;
      left_q  <= left_d;
    end
  end

  always_comb begin
    status           = '0;
    status[0]        = fifo_empty;
    status[1]        = fifo_full;
    status[2]        = underrun_q;
    status[3]        = overflow_q;
    status[4 +: LvlW] = level_q;
  end

  always_comb begin
    rdata = 32'hBADDBEEF;
    case (addr_q)
      8'h00:   rdata = {30'd0, mono_q, en_q};
      8'h04:   rdata = status;
      8'h08:   rdata = '0;
      8'h0C:   rdata = {24'd0, clkdiv_q};
      8'h10:   rdata = 32'(thresh_q);
      default: ;
    endcase
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign SCK           = sck_q;
  assign WS            = ws_q;
  assign SD            = shift_q[31];
  assign IRQ           = irq_q;
endmodule

// File: tb/tb_ahbl_i2s_tx.sv
module tb_ahbl_i2s_tx;
  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic SCK, WS, SD, IRQ;

  ahbl_i2s_tx_if bus ();

  ahbl_i2s_tx #(
    .FIFO_AW   (4),
    .DEF_DIV   (8'd3),
    .DEF_THRESH(4)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus),
    .SCK   (SCK),
    .WS    (WS),
    .SD    (SD),
    .IRQ   (IRQ)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line monitor: one {WS,SD} sample per SCK rising edge (one per slot).
  int unsigned cyc = 0;
  logic        sck_prev = 1'b0;
  logic [1:0]  mon_q[$];
  int unsigned rise_t[$];
  int unsigned irq_cnt = 0;

  always @(negedge HCLK) begin
    cyc      <= cyc + 1;
    sck_prev <= SCK;
    if (SCK && !sck_prev) begin
      mon_q.push_back({WS, SD});
      rise_t.push_back(cyc);
    end
    if (IRQ) irq_cnt <= irq_cnt + 1;
  end

  // Reference model: word queue plus sticky flags.
  logic [31:0] mdl_q[$];
  bit          mdl_ovf = 1'b0;
  bit          mdl_udr = 1'b0;

  function automatic void mdl_push(input logic [31:0] d);
    if (mdl_q.size() >= 16) mdl_ovf = 1'b1;
    else mdl_q.push_back(d);
  endfunction

  function automatic logic [31:0] mdl_status();
    int n = mdl_q.size();
    return (32'(n) << 4) | {28'd0, mdl_ovf, mdl_udr, n == 16, n == 0};
  endfunction

  task automatic mdl_pop(input bit en, input int thr, inout int irq_exp, output logic [31:0] w);
    if (mdl_q.size() == 0) begin
      w = '0;
      mdl_udr = 1'b1;
    end else begin
      if (en && mdl_q.size() == thr + 1) irq_exp++;
      w = mdl_q.pop_front();
    end
  endtask

  task automatic ahb_write(input logic [7:0] a, input logic [31:0] d, input logic dm = 1'b0);
    @(posedge HCLK); #1;
    bus.HADDR = {24'd0, a};
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b1;
    bus.HSEL = 1'b1;
    bus.DMAC_interaction = dm;
    @(posedge HCLK); #1;
    bus.HTRANS = 2'b00;
    bus.HSEL = 1'b0;
    bus.HWRITE = 1'b0;
    bus.HWDATA = d;
    @(posedge HCLK); #1;
    bus.DMAC_interaction = 1'b0;
    if (dm || a == 8'h08) mdl_push(d);
    else if (a == 8'h00 && d[2]) mdl_q.delete();
  endtask

  task automatic ahb_read(input logic [7:0] a, output logic [31:0] d);
    @(posedge HCLK); #1;
    bus.HADDR = {24'd0, a};
    bus.HTRANS = 2'b10;
    bus.HWRITE = 1'b0;
    bus.HSEL = 1'b1;
    @(posedge HCLK); #1;
    bus.HTRANS = 2'b00;
    bus.HSEL = 1'b0;
    d = bus.HRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_read(a, d);
    check_val(tag, d, exp);
  endtask

  task automatic status_check(input string tag);
    read_check(tag, 8'h04, mdl_status());
    mdl_ovf = 1'b0;
    mdl_udr = 1'b0;
  endtask

  task automatic wait_slots(input string tag, input int target, input int budget);
    int c = 0;
    while (mon_q.size() < target && c < budget) begin
      @(posedge HCLK); #1;
      c++;
    end
    check_val(tag, mon_q.size() >= target, 1);
  endtask

  // Play everything queued, stopping EN early in the last frame.
  task automatic run_frames(input string tag, input logic mono, input logic [7:0] div,
                            input int thr);
    int n, frames, irq_exp, base, irq0, budget, idx, p, pmin, pmax;
    logic [31:0] l, r;
    logic [63:0] v, gsd, gws, ws_v;
    logic [63:0] sd_q[$];
    logic [1:0]  s;
    n = mdl_q.size();
    frames = mono ? n : (n + 1) / 2;
    irq_exp = 0;
    for (int k = 0; k < 64; k++) ws_v[k] = (k >= 31 && k <= 62);
    for (int f = 0; f < frames; f++) begin
      mdl_pop(1'b1, thr, irq_exp, l);
      if (mono) r = l;
      else mdl_pop(f != frames - 1, thr, irq_exp, r);
      for (int k = 0; k < 32; k++) begin
        v[k] = l[31-k];
        v[32+k] = r[31-k];
      end
      sd_q.push_back(v);
    end
    ahb_write(8'h0C, {24'd0, div});
    ahb_write(8'h10, 32'(thr));
    base = mon_q.size();
    irq0 = irq_cnt;
    budget = 64 * frames * 2 * (int'(div) + 1) + 400;
    ahb_write(8'h00, {30'd0, mono, 1'b1});
    wait_slots({tag, "_start"}, base + 64 * (frames - 1) + 10, budget);
    ahb_write(8'h00, {30'd0, mono, 1'b0});
    wait_slots({tag, "_end"}, base + 64 * frames, budget);
    repeat (4 * (int'(div) + 1) + 8) @(posedge HCLK);
    #1;
    check_val({tag, "_slots"}, mon_q.size() - base, 64 * frames);
    check_val({tag, "_idle"}, {SCK, WS, SD}, 3'b000);
    for (int f = 0; f < frames; f++) begin
      for (int k = 0; k < 64; k++) begin
        idx = base + 64 * f + k;
        s = (idx < mon_q.size()) ? mon_q[idx] : 2'bxx;
        gws[k] = s[1];
        gsd[k] = s[0];
      end
      check_val($sformatf("%s_sd%0d", tag, f), gsd, sd_q[f]);
      check_val($sformatf("%s_ws%0d", tag, f), gws, ws_v);
    end
    pmin = 32'h7FFF_FFFF;
    pmax = 0;
    for (int i = base + 1; i < base + 64 * frames && i < rise_t.size(); i++) begin
      p = rise_t[i] - rise_t[i-1];
      if (p < pmin) pmin = p;
      if (p > pmax) pmax = p;
    end
    check_val({tag, "_pmin"}, pmin, 2 * (int'(div) + 1));
    check_val({tag, "_pmax"}, pmax, 2 * (int'(div) + 1));
    check_val({tag, "_irq"}, irq_cnt - irq0, irq_exp);
    status_check({tag, "_status"});
  endtask

  initial begin
    int base, irq0, n;
    logic [7:0] div;
    logic mono;
    bus.HADDR = '0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE = 3'b010;
    bus.HWDATA = '0;
    bus.HSEL = 1'b0;
    bus.HREADY = 1'b1;
    bus.DMAC_interaction = 1'b0;

    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    check_val("rst_out", {SCK, WS, SD, IRQ}, 4'b0000);
    HRESET = 1'b0;
    read_check("rst_ctrl", 8'h00, 32'h0);
    status_check("rst_status");
    read_check("rst_clkdiv", 8'h0C, 32'd3);
    read_check("rst_thresh", 8'h10, 32'd4);
    read_check("unmapped", 8'h20, 32'hBADDBEEF);
    read_check("txdata_rd", 8'h08, 32'h0);
    check_val("hreadyout", bus.HREADYOUT, 1'b1);

    // Known pattern: SD high only in slots 0, 31 and 33.
    ahb_write(8'h08, 32'h8000_0001);
    ahb_write(8'h08, 32'h4000_0000);
    run_frames("pat", 1'b0, 8'd1, 4);

    // Single word: right channel underruns, flag clears on read.
    ahb_write(8'h08, 32'hA5A5_0F0F);
    run_frames("udr", 1'b0, 8'd0, 4);
    status_check("udr_cleared");

    // Overflow then drain of the first 16 words.
    for (int i = 0; i < 17; i++) ahb_write(8'h08, $urandom);
    status_check("ovf_status");
    run_frames("drain", 1'b0, 8'd0, 4);

    // Mono duplication.
    ahb_write(8'h08, 32'hF000_0000);
    run_frames("mono", 1'b1, 8'd2, 4);

    // Low-water IRQ.
    for (int i = 0; i < 4; i++) ahb_write(8'h08, $urandom);
    run_frames("irq", 1'b0, 8'd0, 2);

    // DMAC push ignores the register decode; FLUSH empties without IRQ.
    ahb_write(8'h00, 32'h2);
    ahb_write(8'h00, 32'hCAFE_0001, 1'b1);
    read_check("dmac_ctrl", 8'h00, 32'h2);
    status_check("dmac_status");
    ahb_write(8'h10, 32'd0);
    base = mon_q.size();
    irq0 = irq_cnt;
    ahb_write(8'h00, 32'h5);
    repeat (20) @(posedge HCLK);
    #1;
    check_val("flush_irq", irq_cnt - irq0, 0);
    check_val("flush_quiet", mon_q.size() - base, 0);
    status_check("flush_status");
    read_check("flush_ctrl", 8'h00, 32'h1);
    ahb_write(8'h00, 32'h0);

    // Randomized playback runs.
    for (int it = 0; it < 8; it++) begin
      div = 8'($urandom_range(0, 3));
      mono = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) ahb_write(8'($urandom_range(0, 7) * 4), $urandom, 1'b1);
        else ahb_write(8'h08, $urandom);
      end
      run_frames($sformatf("rnd%0d", it), mono, div, $urandom_range(0, 5));
    end

    // Reset in the middle of a frame.
    ahb_write(8'h08, $urandom);
    ahb_write(8'h08, $urandom);
    ahb_write(8'h0C, 32'd0);
    base = mon_q.size();
    ahb_write(8'h00, 32'h1);
    wait_slots("rst_run", base + 20, 2000);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    check_val("rst_mid_out", {SCK, WS, SD, IRQ}, 4'b0000);
    HRESET = 1'b0;
    mdl_q.delete();
    mdl_ovf = 1'b0;
    mdl_udr = 1'b0;
    base = mon_q.size();
    read_check("rst_mid_ctrl", 8'h00, 32'h0);
    status_check("rst_mid_status");
    read_check("rst_mid_clkdiv", 8'h0C, 32'd3);
    repeat (40) @(posedge HCLK);
    #1;
    check_val("rst_mid_quiet", mon_q.size() - base, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
